// File: rtl/issue_window.sv
// issue_window: N-wide in-order issue stage. It picks the longest legal group from the FIFO head,
// registers it onto the issue slots, tracks branch delay slots and keeps performance counters.
module issue_window #(
   parameter int ISSUE_W = 2,
   parameter int CNT_W   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         single_mode,
   input  logic [64*ISSUE_W-1:0]        fifo_data,
   input  logic [ISSUE_W-1:0]           fifo_ok,
   input  logic [ISSUE_W-1:0]           hint_w_ena,
   input  logic [5*ISSUE_W-1:0]         hint_w_dst,
   input  logic [5*ISSUE_W-1:0]         hint_rs,
   input  logic [5*ISSUE_W-1:0]         hint_rt,
   input  logic [ISSUE_W-1:0]           hint_jmp,
   input  logic [ISSUE_W-1:0]           hint_ls,
   input  logic [ISSUE_W-1:0]           hint_hilo,
   input  logic [ISSUE_W-1:0]           hint_cop0,
   output logic [$clog2(ISSUE_W+1)-1:0] pop_cnt,
   output logic [ISSUE_W-1:0]           iss_valid,
   output logic [32*ISSUE_W-1:0]        iss_pc,
   output logic [32*ISSUE_W-1:0]        iss_inst,
   output logic [ISSUE_W-1:0]           iss_in_ds,
   output logic [ISSUE_W-1:0]           iss_adel,
   output logic [CNT_W-1:0]             perf_inst,
   output logic [CNT_W-1:0]             perf_multi,
   output logic [CNT_W-1:0]             perf_stall
);

   localparam int PW = $clog2(ISSUE_W+1);

   typedef enum logic {DS_IDLE = 1'b0, DS_PEND = 1'b1} ds_state_e;

   ds_state_e              ds_q, ds_d;
   logic [ISSUE_W:0]       grp_s;
   logic                   end_s, cls_s, raw_s;
   logic [PW-1:0]          pop_s;
   logic [ISSUE_W-1:0]     in_ds_s, adel_s;
   logic [ISSUE_W-1:0]     iss_valid_q, iss_valid_d, iss_in_ds_q, iss_in_ds_d, iss_adel_q, iss_adel_d;
   logic [32*ISSUE_W-1:0]  iss_pc_q, iss_pc_d, iss_inst_q, iss_inst_d;
   logic [CNT_W-1:0]       perf_inst_q, perf_inst_d, perf_multi_q, perf_multi_d, perf_stall_q, perf_stall_d;
   logic                   unused_hints_s;

   // Slot 0 sources and the youngest slot's destination never feed a hazard check.
   assign unused_hints_s = ^{hint_rs[4:0], hint_rt[4:0], hint_w_ena[ISSUE_W-1], hint_w_dst[5*ISSUE_W-1 -: 5]};

   // Group selection: forward pass for legality, backward pass drops jumps lacking their delay slot.
   always_comb begin
      grp_s = '0;
      end_s = 1'b0;
      cls_s = 1'b0;
      raw_s = 1'b0;
      if (!rst && !stall && !flush) begin
         grp_s[0] = fifo_ok[0];
         end_s    = (ds_q == DS_PEND);
         cls_s    = hint_ls[0] | hint_hilo[0] | hint_cop0[0];
         for (int i = 1; i < ISSUE_W; i++) begin
            raw_s = 1'b0;
            for (int j = 0; j < i; j++) begin
               if (hint_w_ena[j] &&
                   ((hint_w_dst[5*j +: 5] == hint_rs[5*i +: 5] && hint_rs[5*i +: 5] != 5'd0) ||
                    (hint_w_dst[5*j +: 5] == hint_rt[5*i +: 5] && hint_rt[5*i +: 5] != 5'd0))) begin
                  raw_s = 1'b1;
               end else begin
                  raw_s = raw_s;
               end
            end
            grp_s[i] = grp_s[i-1] & ~end_s & fifo_ok[i] & ~single_mode & ~cls_s & ~hint_cop0[i] &
                       (hint_jmp[i-1] | ~raw_s);
            end_s    = end_s | hint_jmp[i-1];
            cls_s    = cls_s | hint_ls[i] | hint_hilo[i] | hint_cop0[i];
         end
         for (int i = ISSUE_W-1; i >= 1; i--) begin
            if (grp_s[i] && hint_jmp[i] && !grp_s[i+1]) begin
               for (int k = i; k < ISSUE_W; k++) begin
                  grp_s[k] = 1'b0;
               end
            end else begin
               grp_s = grp_s;
            end
         end
      end else begin
         grp_s = '0;
      end
   end

   // Per-slot side information and the pop count.
   always_comb begin
      pop_s   = '0;
      in_ds_s = '0;
      adel_s  = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         pop_s     = pop_s + PW'(grp_s[i]);
         in_ds_s[i] = (i == 0) ? (ds_q == DS_PEND) : hint_jmp[(i == 0) ? 0 : i-1];
         adel_s[i] = (fifo_data[64*i+32 +: 2] != 2'b00);
      end
   end

   assign pop_cnt = pop_s;

   // Delay-slot tracker: a lone slot-0 jump leaves its delay slot for a later cycle.
   always_comb begin
      ds_d = ds_q;
      if (flush) begin
         ds_d = DS_IDLE;
      end else if (stall) begin
         ds_d = ds_q;
      end else if (ds_q == DS_PEND) begin
         ds_d = grp_s[0] ? DS_IDLE : DS_PEND;
      end else if (grp_s[0] && hint_jmp[0] && !grp_s[1]) begin
         ds_d = DS_PEND;
      end else begin
         ds_d = DS_IDLE;
      end
   end

   // Next values of the issue registers and counters.
   always_comb begin
      iss_valid_d  = iss_valid_q;
      iss_pc_d     = iss_pc_q;
      iss_inst_d   = iss_inst_q;
      iss_in_ds_d  = iss_in_ds_q;
      iss_adel_d   = iss_adel_q;
      perf_inst_d  = perf_inst_q + CNT_W'(pop_s);
      perf_multi_d = perf_multi_q;
      perf_stall_d = perf_stall_q;
      if (flush) begin
         iss_valid_d = '0;
      end else if (stall) begin
         iss_valid_d = iss_valid_q;
      end else begin
         iss_valid_d = grp_s[ISSUE_W-1:0];
         iss_in_ds_d = in_ds_s;
         iss_adel_d  = adel_s;
         for (int i = 0; i < ISSUE_W; i++) begin
            iss_pc_d[32*i +: 32]   = fifo_data[64*i+32 +: 32];
            iss_inst_d[32*i +: 32] = fifo_data[64*i +: 32];
         end
      end
      if (int'(pop_s) >= 2) begin
         perf_multi_d = perf_multi_q + CNT_W'(1'b1);
      end else begin
         perf_multi_d = perf_multi_q;
      end
      if (stall && fifo_ok[0] && !flush) begin
         perf_stall_d = perf_stall_q + CNT_W'(1'b1);
      end else begin
         perf_stall_d = perf_stall_q;
      end
   end

   // State, issue and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ds_q         <= DS_IDLE;
         iss_valid_q  <= '0;
         iss_pc_q     <= '0;
         iss_inst_q   <= '0;
         iss_in_ds_q  <= '0;
         iss_adel_q   <= '0;
         perf_inst_q  <= '0;
         perf_multi_q <= '0;
         perf_stall_q <= '0;
      end else begin
         ds_q         <= ds_d;
         iss_valid_q  <= iss_valid_d;
         iss_pc_q     <= iss_pc_d;
         iss_inst_q   <= iss_inst_d;
         iss_in_ds_q  <= iss_in_ds_d;
         iss_adel_q   <= iss_adel_d;
         perf_inst_q  <= perf_inst_d;
         perf_multi_q <= perf_multi_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign iss_valid  = iss_valid_q;
   assign iss_pc     = iss_pc_q;
   assign iss_inst   = iss_inst_q;
   assign iss_in_ds  = iss_in_ds_q;
   assign iss_adel   = iss_adel_q;
   assign perf_inst  = perf_inst_q;
   assign perf_multi = perf_multi_q;
   assign perf_stall = perf_stall_q;

endmodule

// File: tb/tb_issue_window.sv
// Scoreboard bench for issue_window (ISSUE_W=2): the driver queues expected pop counts and
// issue-register contents; two monitors check pop_cnt before the edge and iss_* after it.
module tb_issue_window;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, stall, flush, single_mode;
   logic [127:0] fifo_data;
   logic [1:0]   fifo_ok, hint_w_ena, hint_jmp, hint_ls, hint_hilo, hint_cop0;
   logic [9:0]   hint_w_dst, hint_rs, hint_rt;
   logic [1:0]   pop_cnt, iss_valid, iss_in_ds, iss_adel;
   logic [63:0]  iss_pc, iss_inst;
   logic [31:0]  perf_inst, perf_multi, perf_stall;

   issue_window #(.ISSUE_W(2), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .single_mode(single_mode),
      .fifo_data(fifo_data), .fifo_ok(fifo_ok), .hint_w_ena(hint_w_ena), .hint_w_dst(hint_w_dst),
      .hint_rs(hint_rs), .hint_rt(hint_rt), .hint_jmp(hint_jmp), .hint_ls(hint_ls),
      .hint_hilo(hint_hilo), .hint_cop0(hint_cop0), .pop_cnt(pop_cnt), .iss_valid(iss_valid),
      .iss_pc(iss_pc), .iss_inst(iss_inst), .iss_in_ds(iss_in_ds), .iss_adel(iss_adel),
      .perf_inst(perf_inst), .perf_multi(perf_multi), .perf_stall(perf_stall));

   typedef struct packed {
      logic [1:0]  pop;
      logic [1:0]  val;
      logic [1:0]  ds;
      logic [63:0] e0;
      logic [63:0] e1;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        pend_q[$];
   logic [63:0] last0, last1;
   int          n_tot  = 0;
   int          n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Pop count is combinational: sample mid-cycle, well before the next rising edge.
   always @(negedge clk) begin
      exp_t it;
      #2;
      if (exp_q.size() > 0) begin
         it = exp_q.pop_front();
         chk("pop_cnt", 64'(pop_cnt), 64'(it.pop));
         pend_q.push_back(it);
      end
   end

   // Issue registers: sample just after the edge that loaded them.
   always @(posedge clk) begin
      exp_t mt;
      #1;
      if (pend_q.size() > 0) begin
         mt = pend_q.pop_front();
         chk("iss_valid", 64'(iss_valid), 64'(mt.val));
         chk("iss_in_ds", 64'(iss_in_ds & mt.val), 64'(mt.ds));
         if (mt.val[0]) begin
            chk("iss_pc0", 64'(iss_pc[31:0]), 64'(mt.e0[63:32]));
            chk("iss_inst0", 64'(iss_inst[31:0]), 64'(mt.e0[31:0]));
            chk("iss_adel0", 64'(iss_adel[0]), 64'(mt.e0[33:32] != 2'b00));
         end
         if (mt.val[1]) begin
            chk("iss_pc1", 64'(iss_pc[63:32]), 64'(mt.e1[63:32]));
            chk("iss_inst1", 64'(iss_inst[63:32]), 64'(mt.e1[31:0]));
            chk("iss_adel1", 64'(iss_adel[1]), 64'(mt.e1[33:32] != 2'b00));
         end
      end
   end

   task automatic clr(input int k);
      fifo_ok     = 2'b11;
      hint_w_ena  = 2'b00;
      hint_w_dst  = 10'd0;
      hint_rs     = 10'd0;
      hint_rt     = 10'd0;
      hint_jmp    = 2'b00;
      hint_ls     = 2'b00;
      hint_hilo   = 2'b00;
      hint_cop0   = 2'b00;
      stall       = 1'b0;
      flush       = 1'b0;
      single_mode = 1'b0;
      fifo_data   = {32'h0000_2004 + 32'(k*8), 32'hB000_0000 + 32'(k),
                     32'h0000_2000 + 32'(k*8), 32'hA000_0000 + 32'(k)};
   endtask

   // hold=1: the issue registers are expected to keep the last loaded entries.
   task automatic step(input logic [1:0] e_pop, input logic [1:0] e_val, input logic [1:0] e_ds,
                       input logic hold);
      exp_t it;
      if (!hold) begin
         last0 = fifo_data[63:0];
         last1 = fifo_data[127:64];
      end
      it.pop = e_pop;
      it.val = e_val;
      it.ds  = e_ds;
      it.e0  = last0;
      it.e1  = last1;
      exp_q.push_back(it);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clr(0);
      @(negedge clk);
      step(2'd0, 2'b00, 2'b00, 1'b0);
      step(2'd0, 2'b00, 2'b00, 1'b0);
      chk("perf_inst_rst", 64'(perf_inst), 64'd0);
      chk("perf_multi_rst", 64'(perf_multi), 64'd0);
      chk("perf_stall_rst", 64'(perf_stall), 64'd0);
      rst = 1'b0;

      clr(1); hint_w_ena = 2'b11; hint_w_dst = {5'd2, 5'd1}; hint_rs = {5'd3, 5'd0}; hint_rt = {5'd4, 5'd0};
      step(2'd2, 2'b11, 2'b00, 1'b0);
      chk("perf_inst_first", 64'(perf_inst), 64'd2);
      chk("perf_multi_first", 64'(perf_multi), 64'd1);

      clr(2); hint_w_ena = 2'b01; hint_w_dst = {5'd0, 5'd5}; hint_rs = {5'd5, 5'd0};
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(3); hint_w_ena = 2'b01; fifo_data[33:32] = 2'b10;
      step(2'd2, 2'b11, 2'b00, 1'b0);
      clr(4); hint_w_ena = 2'b01; hint_w_dst = {5'd0, 5'd7}; hint_rt = {5'd7, 5'd0};
      step(2'd1, 2'b01, 2'b00, 1'b0);

      clr(5); fifo_ok = 2'b01; hint_jmp = 2'b01;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(6);
      step(2'd1, 2'b01, 2'b01, 1'b0);
      clr(7);
      step(2'd2, 2'b11, 2'b00, 1'b0);

      clr(8); hint_jmp = 2'b01; hint_w_ena = 2'b01; hint_w_dst = {5'd0, 5'd31}; hint_rs = {5'd31, 5'd0};
      step(2'd2, 2'b11, 2'b10, 1'b0);
      clr(9);
      step(2'd2, 2'b11, 2'b00, 1'b0);
      clr(10); hint_jmp = 2'b10;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(11); hint_jmp = 2'b01;
      step(2'd2, 2'b11, 2'b10, 1'b0);

      clr(12); single_mode = 1'b1;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(13); single_mode = 1'b1; hint_jmp = 2'b01;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(14); single_mode = 1'b1;
      step(2'd1, 2'b01, 2'b01, 1'b0);

      clr(15); hint_cop0 = 2'b10;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(16); hint_ls = 2'b01;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(17); hint_cop0 = 2'b01;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(18); hint_hilo = 2'b01;
      step(2'd1, 2'b01, 2'b00, 1'b0);

      clr(19);
      step(2'd2, 2'b11, 2'b00, 1'b0);
      chk("perf_inst_mid", 64'(perf_inst), 64'd27);
      chk("perf_multi_mid", 64'(perf_multi), 64'd7);

      clr(20); stall = 1'b1;
      step(2'd0, 2'b11, 2'b00, 1'b1);
      step(2'd0, 2'b11, 2'b00, 1'b1);
      step(2'd0, 2'b11, 2'b00, 1'b1);
      chk("perf_stall_3", 64'(perf_stall), 64'd3);
      chk("perf_inst_stall", 64'(perf_inst), 64'd27);
      clr(21); stall = 1'b1; fifo_ok = 2'b00;
      step(2'd0, 2'b11, 2'b00, 1'b1);
      chk("perf_stall_empty", 64'(perf_stall), 64'd3);

      clr(22); fifo_ok = 2'b01; hint_jmp = 2'b01;
      step(2'd1, 2'b01, 2'b00, 1'b0);
      clr(23); flush = 1'b1;
      step(2'd0, 2'b00, 2'b00, 1'b0);
      clr(24);
      step(2'd2, 2'b11, 2'b00, 1'b0);
      clr(25); flush = 1'b1; stall = 1'b1;
      step(2'd0, 2'b00, 2'b00, 1'b0);
      chk("perf_inst_end", 64'(perf_inst), 64'd30);
      chk("perf_multi_end", 64'(perf_multi), 64'd8);
      chk("perf_stall_end", 64'(perf_stall), 64'd3);

      clr(26); fifo_ok = 2'b00;
      repeat (3) @(negedge clk);
      chk("scoreboard_drain", 64'(exp_q.size() + pend_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
